// File: rtl/secuenciador_reset.sv
// secuenciador_reset
//
// Reset sequencer. It takes the one-cycle pulse from the push-button
// conditioning stage, and the asynchronous board reset at power-up. From
// these it releases the system reset in stages:
//   1. Core logic is released after HOLD_CYCLES.
//   2. Peripheral logic is released GAP_CYCLES later, and init_start pulses.
//   3. The sequencer waits for init_done from the downstream init FSM and
//      then raises listo.
//
// Optional feature: when the macro SEQ_TIMEOUT_EN is defined, the wait for
// init_done is limited to TIMEOUT_CYCLES. If it expires, error_init and listo
// are both raised. When the macro is undefined, the wait has no limit and
// error_init is tied low.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   pulso_rst   in   one-cycle restart request, synchronous to clk
//   init_done   in   level from the init FSM, high = initialisation complete
//   rst_nucleo  out  active-high reset for core logic
//   rst_perif   out  active-high reset for peripheral/driver logic
//   init_start  out  one-cycle pulse that starts the init FSM
//   listo       out  system released and initialised
//   error_init  out  sticky init timeout flag
module secuenciador_reset #(
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulso_rst,
  input  logic init_done,
  output logic rst_nucleo,
  output logic rst_perif,
  output logic init_start,
  output logic listo,
  output logic error_init
);

  // Reject illegal parameter values at elaboration time.
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("secuenciador_reset: HOLD_CYCLES, GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
`ifdef SEQ_TIMEOUT_EN
  localparam int MAX_CNT = (TIMEOUT_CYCLES > MAX_HG) ? TIMEOUT_CYCLES : MAX_HG;
`else
  localparam int MAX_CNT = MAX_HG;
`endif
  localparam int CNT_W = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    GAP       = 2'd1,
    INIT_WAIT = 2'd2,
    READY     = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             nucleo_nx, perif_nx, start_nx, listo_nx;
`ifdef SEQ_TIMEOUT_EN
  logic             error_nx;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HOLD;
      cnt        <= '0;
      rst_nucleo <= 1'b1;
      rst_perif  <= 1'b1;
      init_start <= 1'b0;
      listo      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      rst_nucleo <= nucleo_nx;
      rst_perif  <= perif_nx;
      init_start <= start_nx;
      listo      <= listo_nx;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_init <= 1'b0;
    end else begin
      error_init <= error_nx;
    end
  end
`else
  assign error_init = 1'b0;
`endif

  // Next state and next output values. The restart request is checked
  // before anything else, so it overrides terminal counts and init_done
  // arriving on the same edge.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    nucleo_nx = rst_nucleo;
    perif_nx  = rst_perif;
    start_nx  = 1'b0;
    listo_nx  = listo;
`ifdef SEQ_TIMEOUT_EN
    error_nx  = error_init;
`endif

    if (pulso_rst) begin
      state_nx  = HOLD;
      cnt_nx    = '0;
      nucleo_nx = 1'b1;
      perif_nx  = 1'b1;
      listo_nx  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      error_nx  = 1'b0;
`endif
    end else begin
      unique case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            nucleo_nx = 1'b0;
            cnt_nx    = '0;
            state_nx  = GAP;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            perif_nx = 1'b0;
            start_nx = 1'b1;
            cnt_nx   = '0;
            state_nx = INIT_WAIT;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        INIT_WAIT: begin
          // init_done wins over a timeout that expires on the same edge.
          if (init_done) begin
            listo_nx = 1'b1;
            state_nx = READY;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (cnt == TMO_LAST) begin
            listo_nx = 1'b1;
            error_nx = 1'b1;
            state_nx = READY;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
`endif
        end
        READY: begin
          state_nx = READY;
        end
        default: begin
          state_nx = HOLD;
        end
      endcase
    end
  end

endmodule
